// File: rtl/uart_rx_led.sv
// 8N1 UART receiver: two-flop input synchroniser, baud-counting FSM, byte/valid/LED outputs.
// Frames with a low stop bit raise frame_err and park in BREAK until the line returns high.
module uart_rx_led #(
  parameter int BAUD_RATE  = 9600,
  parameter int CLOCK_FREQ = 100_000_000,
  parameter int BAUD_GEN   = CLOCK_FREQ / BAUD_RATE,
  parameter int HALF_GEN   = BAUD_GEN / 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy,
  output logic [3:0] led
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  localparam logic [15:0] C_FULL = 16'(BAUD_GEN - 1);
  localparam logic [15:0] C_HALF = 16'(HALF_GEN - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_sync1;
  logic        r_rx_s;
  logic [15:0] r_cnt;
  logic [2:0]  r_bit_count;
  logic [7:0]  r_shift;
  logic [7:0]  r_data_out;
  logic [3:0]  r_led;
  logic        r_data_valid;
  logic        r_frame_err;
  logic        r_busy;

  logic w_full_hit;
  logic w_half_hit;
  logic w_sample_data;
  logic w_stop_good;
  logic w_stop_bad;
  logic w_enter_data;
  logic w_cnt_clr;
  logic w_cnt_en;

  assign w_full_hit = (r_cnt == C_FULL);
  assign w_half_hit = (r_cnt == C_HALF);

  // Both synchroniser flops reset high so reset never looks like a start bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      r_sync1 <= rx;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves the signal unassigned (no latch).
    w_state_next = r_state;
    unique case (r_state)
      S_IDLE:  if (!r_rx_s) w_state_next = S_START;
      S_START: if (w_half_hit) w_state_next = r_rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_full_hit && (r_bit_count == 3'd7)) w_state_next = S_STOP;
      S_STOP:  if (w_full_hit) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
      S_BREAK: if (r_rx_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_sample_data = (r_state == S_DATA) && w_full_hit;
    w_stop_good   = (r_state == S_STOP) && w_full_hit && r_rx_s;
    w_stop_bad    = (r_state == S_STOP) && w_full_hit && !r_rx_s;
    w_enter_data  = (r_state == S_START) && (w_state_next == S_DATA);
    w_cnt_en      = (r_state == S_START) || (r_state == S_DATA) || (r_state == S_STOP);
    w_cnt_clr     = (w_state_next != r_state) || w_sample_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt        <= '0;
      r_bit_count  <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_led        <= '0;
      r_data_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      if (w_cnt_clr)     r_cnt <= '0;
      else if (w_cnt_en) r_cnt <= r_cnt + 16'd1;

      if (w_enter_data)       r_bit_count <= '0;
      else if (w_sample_data) r_bit_count <= r_bit_count + 3'd1;

      if (w_sample_data) r_shift <= {r_rx_s, r_shift[7:1]};

      r_data_valid <= w_stop_good;
      if (w_stop_good) begin
        r_data_out  <= r_shift;
        r_led       <= r_shift[3:0];
        r_frame_err <= 1'b0;
      end else if (w_stop_bad) begin
        r_frame_err <= 1'b1;
      end

      r_busy <= (w_state_next != S_IDLE);
    end
  end

  assign data_out   = r_data_out;
  assign led        = r_led;
  assign data_valid = r_data_valid;
  assign frame_err  = r_frame_err;
  assign busy       = r_busy;

endmodule

// File: doc/uart_rx_led.md
# uart_rx_led

Serial receive path for the board's UART link: deserialises 8N1 frames arriving on `rx` at `BAUD_RATE` and presents each byte on a parallel bus with a one-cycle valid strobe. It mirrors the LED readback of the transmit path by latching the low nibble of every good byte onto `led`. The block flags malformed frames (bad stop bit) and rejects start-bit glitches. It sits between the board's UART RX pin and the user logic and LEDs.

## Interface
- `BAUD_RATE`, 9600, serial bit rate in bits/s
- `CLOCK_FREQ`, 100_000_000, `clk` frequency in Hz
- `BAUD_GEN`, `CLOCK_FREQ/BAUD_RATE`, clock cycles per bit; legal range 4..65535
- `HALF_GEN`, `BAUD_GEN/2`, cycles from start-bit detection to start-bit centre sample
- `clk`  in  1  system clock; all logic is on the rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rx`  in  1  UART serial input; idles high; asynchronous to `clk`
- `data_out`  out  8  last correctly received byte
- `data_valid`  out  1  one-cycle pulse when `data_out` is updated
- `frame_err`  out  1  set when the stop bit samples low; cleared by the next good frame
- `busy`  out  1  high whenever the FSM is not in IDLE
- `led`  out  4  `data_out[3:0]` of the last good frame

## Operation
- Synchroniser: `rx` passes through 2 flip-flops, both reset to 1, to produce `rx_s`. The FSM sees only `rx_s`.
- Baud counter: 16-bit, cleared on every state entry and after every sample.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: when `rx_s`==0, go to START and clear the counter.
- START: count up to `HALF_GEN`-1, then sample `rx_s`.
  - Sample 0: go to DATA with `bit_count`=0.
  - Sample 1: glitch. Return to IDLE with no flag change.
- DATA: at each count of `BAUD_GEN`-1, sample `rx_s` and shift it into `shift_reg` LSB-first (shift right, new bit enters bit 7). Increment `bit_count`.
  - After the 8th sample (`bit_count`==7 at the sample), go to STOP.
- STOP: at count `BAUD_GEN`-1, sample `rx_s`.
  - Sample 1: at that edge, `data_out`<=`shift_reg`, `led`<=`shift_reg[3:0]`, `data_valid`<=1, `frame_err`<=0. Go to IDLE.
  - Sample 0: at that edge, `frame_err`<=1. Go to BREAK. `data_out`, `led` and `data_valid` are unchanged.
- BREAK: wait for `rx_s`==1, then go to IDLE. This prevents a held-low line from being read as repeated 0x00 frames.
- `data_valid` is a registered pulse: it is high in exactly the one cycle following the good stop sample and low otherwise.
- `busy` is registered: it is 1 in every state except IDLE.
- Reset (asynchronous, any time, including mid-frame): all outputs and all internal state return to their reset values immediately. No partial byte is ever presented.

## Timing
- Reset values:
  - `data_out`=0x00, `led`=0x0, `data_valid`=0, `frame_err`=0, `busy`=0.
  - State IDLE, counter 0, `bit_count` 0, `shift_reg` 0x00, both synchroniser flops 1.
- Pad-to-FSM latency: 2 `clk` cycles through the synchroniser.
- T0 is the edge at which IDLE first sees `rx_s`==0.
  - Samples occur at T0 + `HALF_GEN` + k*`BAUD_GEN`: k=0 is the start bit, k=1..8 are data bits 0..7, k=9 is the stop bit.
  - `data_valid` is high during the cycle after the k=9 edge.
- A frame's IDLE is re-entered at the stop-sample edge, so a back-to-back start bit (stop bit exactly one bit-time long) is detected on the next cycle. There is no dead time beyond the stop-sample half-bit.
- A start pulse shorter than `HALF_GEN` cycles at `rx_s` is rejected with no output change. `busy` is high only during that window.

## Test plan
The bench overrides parameters to `CLOCK_FREQ`=1_000_000, `BAUD_RATE`=100_000, which gives `BAUD_GEN`=10 and `HALF_GEN`=5.
- Good frame: drive 0xA5 (8N1, 10 cycles/bit) → `data_out`=0xA5, `led`=0x5, one-cycle `data_valid` exactly `HALF_GEN`+9*`BAUD_GEN`+1 cycles after `rx_s` falls, `frame_err`=0, `busy` back to 0.
- Framing error: drive 0x3C with stop bit low for 30 cycles, then high → `frame_err`=1, no `data_valid`, `data_out`/`led` still hold the previous value, `busy` stays 1 until `rx_s` returns high. A following good 0x0F frame → `frame_err`=0, `data_out`=0x0F, `led`=0xF.
- Glitch: drive `rx` low for 3 cycles, then high → no `data_valid`, `frame_err` unchanged, `busy` back to 0 within `HALF_GEN`+3 cycles.
- Back-to-back: drive 0x00 then 0xFF with single 10-cycle stop bits and no idle gap → two `data_valid` pulses 100 cycles apart, with `data_out` 0x00 then 0xFF.
- Reset mid-frame: assert `rst` for 1 cycle after 4 data bits of 0x81 → all outputs reset asynchronously. A subsequent full 0x81 frame → `data_out`=0x81, `led`=0x1.
- Held-low line: hold `rx`=0 for 300 cycles → exactly one `frame_err` assertion, zero `data_valid` pulses.
